match_sequencer: RTL

- Rule-enforcing controller that owns the point and set registers of the volleyball scoreboard and sequences a match.
- Takes raw team-A/team-B point buttons plus undo, next-set and new-match buttons.
- Applies win-by-2, 25/15-point set targets and best-of-5 rules.
- Drives point/set values, serve indicator and set/match-end flags to the 7-segment and LCD display blocks, replacing free-running per-team counters.

---
 rtl/match_pkg.sv | 43 ++++
 rtl/match_sequencer_if.sv | 39 +++
 rtl/btn_edge.sv | 33 +++
 rtl/match_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
`default_nettype none
// ============================================================================
// match_pkg
// Shared types and default constants for the volleyball match sequencer.
// Revision: 1.0
// ============================================================================
package match_pkg;

    localparam int DEF_PNT_W          = 5;
    localparam int DEF_SET_W          = 2;
    localparam int DEF_PNT_TARGET     = 25;
    localparam int DEF_DECIDER_TARGET = 15;
    localparam int DEF_SETS_TO_WIN    = 3;
    localparam int DEF_PNT_MAX        = 31;

    localparam int BTN_A    = 0;
    localparam int BTN_B    = 1;
    localparam int BTN_UNDO = 2;
    localparam int BTN_NEXT = 3;
    localparam int BTN_NEW  = 4;
    localparam int NUM_BTN  = 5;

    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_SET_OVER   = 2'd1,
        ST_MATCH_OVER = 2'd2
    } state_e;

    typedef enum logic {
        SERVE_A = 1'b0,
        SERVE_B = 1'b1
    } serve_e;

    // Single-level undo record for the most recent point.
    typedef struct packed {
        logic valid;
        logic scorer;       // 0 = A, 1 = B
        logic prior_serve;
        logic sat;          // point was applied as a decrement of the other team
    } hist_t;

endpackage
`default_nettype wire

// File: rtl/match_sequencer_if.sv
`default_nettype none
// ============================================================================
// match_sequencer_if
// Button inputs and scoreboard outputs of the match sequencer.
// Revision: 1.0
// ============================================================================
interface match_sequencer_if #(
    parameter int PNT_W = 5,
    parameter int SET_W = 2
);
    logic             iEN;
    logic             iPNT_A;
    logic             iPNT_B;
    logic             iUNDO;
    logic             iNEXT;
    logic             iNEW_MATCH;
    logic [PNT_W-1:0] oPNT_A;
    logic [PNT_W-1:0] oPNT_B;
    logic [SET_W-1:0] oSET_A;
    logic [SET_W-1:0] oSET_B;
    logic             oSERVE;
    logic             oSET_END;
    logic             oWIN_A;
    logic             oWIN_B;
    logic [1:0]       oSTATE;

    modport master (
        output iEN, iPNT_A, iPNT_B, iUNDO, iNEXT, iNEW_MATCH,
        input  oPNT_A, oPNT_B, oSET_A, oSET_B, oSERVE, oSET_END,
               oWIN_A, oWIN_B, oSTATE
    );

    modport slave (
        input  iEN, iPNT_A, iPNT_B, iUNDO, iNEXT, iNEW_MATCH,
        output oPNT_A, oPNT_B, oSET_A, oSET_B, oSERVE, oSET_END,
               oWIN_A, oWIN_B, oSTATE
    );
endinterface
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ============================================================================
// btn_edge
// Two-flop synchronizer plus rising-edge detector; one-cycle pulse per press.
// Revision: 1.0
// ============================================================================
module btn_edge (
    input  logic iCLK,
    input  logic iRST,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/match_sequencer.sv
`default_nettype none
// ============================================================================
// match_sequencer
// Volleyball scoring FSM: win-by-2, set targets, best-of-N, single-level undo.
// Revision: 1.0
// ============================================================================
module match_sequencer
    import match_pkg::*;
#(
    parameter int PNT_W          = DEF_PNT_W,
    parameter int SET_W          = DEF_SET_W,
    parameter int PNT_TARGET     = DEF_PNT_TARGET,
    parameter int DECIDER_TARGET = DEF_DECIDER_TARGET,
    parameter int SETS_TO_WIN    = DEF_SETS_TO_WIN,
    parameter int PNT_MAX        = DEF_PNT_MAX
) (
    input  logic              iCLK,
    input  logic              iRST,
    match_sequencer_if.slave  bus
);

    localparam logic [PNT_W:0]   TGT_NORM     = (PNT_W+1)'(PNT_TARGET);
    localparam logic [PNT_W:0]   TGT_DEC      = (PNT_W+1)'(DECIDER_TARGET);
    localparam logic [PNT_W:0]   LEAD_MIN     = (PNT_W+1)'(2);
    localparam logic [PNT_W-1:0] PNT_SAT      = PNT_W'(PNT_MAX);
    localparam logic [SET_W:0]   DECIDER_SETS = (SET_W+1)'(2*SETS_TO_WIN-2);
    localparam logic [SET_W-1:0] SETS_WIN     = SET_W'(SETS_TO_WIN);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_ev;

    assign btn_raw[BTN_A]    = bus.iPNT_A;
    assign btn_raw[BTN_B]    = bus.iPNT_B;
    assign btn_raw[BTN_UNDO] = bus.iUNDO;
    assign btn_raw[BTN_NEXT] = bus.iNEXT;
    assign btn_raw[BTN_NEW]  = bus.iNEW_MATCH;

    generate
        for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
            btn_edge u_btn_edge (
                .iCLK    (iCLK),
                .iRST    (iRST),
                .btn_i   (btn_raw[g]),
                .pulse_o (btn_ev[g])
            );
        end
    endgenerate

    logic ev_new;
    logic ev_undo;
    logic ev_next;
    logic pt_a;
    logic pt_b;

    // Coincident A/B points cancel each other; only NEW_MATCH ignores iEN.
    assign ev_new  = btn_ev[BTN_NEW];
    assign ev_undo = btn_ev[BTN_UNDO] & bus.iEN;
    assign ev_next = btn_ev[BTN_NEXT] & bus.iEN;
    assign pt_a    = btn_ev[BTN_A] & ~btn_ev[BTN_B] & bus.iEN;
    assign pt_b    = btn_ev[BTN_B] & ~btn_ev[BTN_A] & bus.iEN;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,   state_d;
    logic [PNT_W-1:0] pnt_a_q,   pnt_a_d;
    logic [PNT_W-1:0] pnt_b_q,   pnt_b_d;
    logic [SET_W-1:0] set_a_q,   set_a_d;
    logic [SET_W-1:0] set_b_q,   set_b_d;
    serve_e           serve_q,   serve_d;
    logic             win_a_q,   win_a_d;
    logic             win_b_q,   win_b_d;
    logic             set_end_q, set_end_d;
    hist_t            hist_q,    hist_d;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= ST_PLAY;
            pnt_a_q   <= '0;
            pnt_b_q   <= '0;
            set_a_q   <= '0;
            set_b_q   <= '0;
            serve_q   <= SERVE_A;
            win_a_q   <= 1'b0;
            win_b_q   <= 1'b0;
            set_end_q <= 1'b0;
            hist_q    <= '0;
        end else begin
            state_q   <= state_d;
            pnt_a_q   <= pnt_a_d;
            pnt_b_q   <= pnt_b_d;
            set_a_q   <= set_a_d;
            set_b_q   <= set_b_d;
            serve_q   <= serve_d;
            win_a_q   <= win_a_d;
            win_b_q   <= win_b_d;
            set_end_q <= set_end_d;
            hist_q    <= hist_d;
        end
    end

    // ------------------------------------------------------------------
    // Point datapath, expressed from the scorer's point of view
    // ------------------------------------------------------------------
    logic             scorer;
    logic [PNT_W-1:0] sc_pts;
    logic [PNT_W-1:0] ot_pts;
    logic [PNT_W-1:0] sc_new;
    logic [PNT_W-1:0] ot_new;
    logic [SET_W-1:0] sc_sets;
    logic [SET_W-1:0] sc_sets_new;
    logic [SET_W:0]   set_sum;
    logic [PNT_W:0]   target;
    logic             sat;
    logic             set_won;

    always_comb begin
        scorer      = pt_b;
        sc_pts      = scorer ? pnt_b_q : pnt_a_q;
        ot_pts      = scorer ? pnt_a_q : pnt_b_q;
        sc_sets     = scorer ? set_b_q : set_a_q;
        sat         = (sc_pts == PNT_SAT);
        // At saturation the lead is advanced by pulling the other team down.
        sc_new      = sat ? sc_pts : sc_pts + 1'b1;
        ot_new      = sat ? ot_pts - 1'b1 : ot_pts;
        set_sum     = {1'b0, set_a_q} + {1'b0, set_b_q};
        target      = (set_sum == DECIDER_SETS) ? TGT_DEC : TGT_NORM;
        set_won     = ({1'b0, sc_new} >= target) &&
                      ({1'b0, sc_new} >= ({1'b0, ot_new} + LEAD_MIN));
        sc_sets_new = sc_sets + 1'b1;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pnt_a_d   = pnt_a_q;
        pnt_b_d   = pnt_b_q;
        set_a_d   = set_a_q;
        set_b_d   = set_b_q;
        serve_d   = serve_q;
        win_a_d   = win_a_q;
        win_b_d   = win_b_q;
        hist_d    = hist_q;

        if (ev_new) begin
            state_d = ST_PLAY;
            pnt_a_d = '0;
            pnt_b_d = '0;
            set_a_d = '0;
            set_b_d = '0;
            serve_d = SERVE_A;
            win_a_d = 1'b0;
            win_b_d = 1'b0;
            hist_d  = '0;
        end else if (ev_undo) begin
            if (hist_q.valid) begin
                if (hist_q.sat) begin
                    if (hist_q.scorer) pnt_a_d = pnt_a_q + 1'b1;
                    else               pnt_b_d = pnt_b_q + 1'b1;
                end else begin
                    if (hist_q.scorer) pnt_b_d = pnt_b_q - 1'b1;
                    else               pnt_a_d = pnt_a_q - 1'b1;
                end
                serve_d = serve_e'(hist_q.prior_serve);
                if (state_q != ST_PLAY) begin
                    if (hist_q.scorer) set_b_d = set_b_q - 1'b1;
                    else               set_a_d = set_a_q - 1'b1;
                    win_a_d = 1'b0;
                    win_b_d = 1'b0;
                    state_d = ST_PLAY;
                end
                hist_d.valid = 1'b0;
            end
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (pt_a || pt_b) begin
                        if (scorer) begin
                            pnt_b_d = sc_new;
                            pnt_a_d = ot_new;
                        end else begin
                            pnt_a_d = sc_new;
                            pnt_b_d = ot_new;
                        end
                        serve_d            = serve_e'(scorer);
                        hist_d.valid       = 1'b1;
                        hist_d.scorer      = scorer;
                        hist_d.prior_serve = serve_q;
                        hist_d.sat         = sat;
                        if (set_won) begin
                            if (scorer) set_b_d = sc_sets_new;
                            else        set_a_d = sc_sets_new;
                            if (sc_sets_new == SETS_WIN) begin
                                state_d = ST_MATCH_OVER;
                                win_a_d = ~scorer;
                                win_b_d = scorer;
                            end else begin
                                state_d = ST_SET_OVER;
                            end
                        end
                    end
                end
                ST_SET_OVER: begin
                    if (ev_next) begin
                        // The team that lost the set serves first in the next one.
                        serve_d      = (pnt_a_q > pnt_b_q) ? SERVE_B : SERVE_A;
                        pnt_a_d      = '0;
                        pnt_b_d      = '0;
                        hist_d.valid = 1'b0;
                        state_d      = ST_PLAY;
                    end
                end
                default: begin
                end
            endcase
        end

        set_end_d = (state_d == ST_SET_OVER);
    end

    assign bus.oPNT_A   = pnt_a_q;
    assign bus.oPNT_B   = pnt_b_q;
    assign bus.oSET_A   = set_a_q;
    assign bus.oSET_B   = set_b_q;
    assign bus.oSERVE   = serve_q;
    assign bus.oSET_END = set_end_q;
    assign bus.oWIN_A   = win_a_q;
    assign bus.oWIN_B   = win_b_q;
    assign bus.oSTATE   = state_q;

endmodule
`default_nettype wire
